seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed digits (legal 1..8).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles each digit is driven (legal >=2).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-005 The block SHALL have port value, input, 4*NUM_DIGITS, meaning hex nibbles; nibble i drives digit i, where digit 0 is least significant.
REQ-006 The block SHALL have port dp_in, input, NUM_DIGITS, meaning the decimal point request per digit, 1 = lit.
REQ-007 The block SHALL have port digit_en, input, NUM_DIGITS, meaning per-digit enable, 0 = blanked.
REQ-008 The block SHALL have port load, input, 1, meaning a one-cycle strobe that captures value, dp_in and digit_en into shadow registers.
REQ-009 The block SHALL have port seg, output, 7, meaning active-low segments, seg[6]=a through seg[0]=g.
REQ-010 The block SHALL have port dp, output, 1, meaning active-low decimal point.
REQ-011 The block SHALL have port an, output, NUM_DIGITS, meaning active-low anodes, with at most one bit low.
REQ-012 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse each time a full scan of all digits completes.

Function
REQ-013 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; each wrap is a "tick".
REQ-014 On each tick, the digit index SHALL advance by 1, and NUM_DIGITS-1 SHALL wrap to 0.
REQ-015 frame_done SHALL be 1 for exactly the cycle after a tick that wraps the index from NUM_DIGITS-1 to 0.
REQ-016 When load=1, the shadow registers SHALL update at that clock edge; the display SHALL use only the shadow registers, never the live inputs.
REQ-017 A load coincident with a tick SHALL be applied; the newly selected digit SHALL show the new data.
REQ-018 seg, dp and an SHALL be registered, reflecting the current index and shadow with one cycle of latency.
REQ-019 For an enabled digit: an SHALL be ~(1<<index), dp SHALL be ~dp_shadow[index], and seg SHALL be the glyph of nibble[index].
REQ-020 Glyph table (seg[6:0]): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 For a blanked digit: an SHALL be all ones, seg SHALL be 1111111, and dp SHALL be 1; scan timing SHALL be unchanged.
REQ-022 When NUM_DIGITS=1, the index SHALL stay 0, and frame_done SHALL pulse on every tick.

Reset
REQ-023 With reset=1 at an edge: prescaler=0, index=0, shadow value=0, shadow dp=0, shadow digit_en=all ones, an=all ones, seg=1111111, dp=1, frame_done=0.
REQ-024 Reset SHALL override a coincident load.
REQ-025 Reset asserted mid-scan SHALL restart the scan at digit 0 with a full REFRESH_DIV dwell.
REQ-026 On the first cycle after reset release, an SHALL equal ~1 and seg SHALL be 0000001.

Configuration
REQ-027 The macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-028 With LEADING_ZERO_BLANK_EN defined: digit i>0 SHALL be blanked when nibble i and all higher nibbles are 0.
REQ-029 With LEADING_ZERO_BLANK_EN defined: digit 0 SHALL never be blanked by this rule, and dp_shadow[i]=1 SHALL exempt digit i from this rule.
REQ-030 Without LEADING_ZERO_BLANK_EN, zero nibbles SHALL display as "0", and only digit_en SHALL blank.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-031 Reset then idle: an SHALL sequence 1110, 1101, 1011, 0111, 1110, each for 4 cycles, with seg=0000001 throughout; frame_done SHALL pulse once per 16 cycles.
REQ-032 load with value=16'hA3F1 and dp_in=4'b0100: the digit sequence SHALL show seg 1001111, 0111000, 0000110, 0001000; dp SHALL be 0 only while an=1011.
REQ-033 Change value without load: seg SHALL be unchanged; then load coincident with the last prescaler count: the new digit SHALL show the new nibble immediately.
REQ-034 load with digit_en=4'b1010: during digits 0 and 2, an SHALL be 1111 and seg SHALL be 1111111; digits 1 and 3 SHALL display normally.
REQ-035 Assert reset on digit 2, cycle 2: on the next cycle an SHALL be 1111; after release, an SHALL be 1110 and seg SHALL be 0000001.
REQ-036 With LEADING_ZERO_BLANK_EN and value=16'h0070: digits 3 and 2 SHALL be blanked, digit 1 SHALL show 0001111, and digit 0 SHALL show 0000001; without the macro, all four digits SHALL be lit.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. A prescaler sets how long each digit is driven, and
// the digit index steps once per prescaler wrap. The display reads only the
// shadow registers, which are captured on 'load'. All outputs are registered
// and active-low.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading-zero
// digits. Digit 0, and any digit whose decimal point is lit, is never
// blanked by this rule.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      load,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_val_sh;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_en_sh;

  logic                    w_tick;
  logic                    w_last_digit;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [NUM_DIGITS-1:0]   w_lzb;
  logic [NUM_DIGITS-1:0]   w_en_eff;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_vis;

  // Hex nibble to active-low segment pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_last_digit = (r_idx == IDX_LAST);

  // Prescaler: counts the dwell of each digit and wraps to form the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Digit index: advances once per tick, wrapping after the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= w_last_digit ? '0 : (r_idx + IW'(1));
    end else begin
      r_idx <= r_idx;
    end
  end

  // Shadow registers: the only data source the display ever reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_val_sh <= '0;
      r_dp_sh  <= '0;
      r_en_sh  <= '1;
    end else if (load) begin
      r_val_sh <= value;
      r_dp_sh  <= dp_in;
      r_en_sh  <= digit_en;
    end else begin
      r_val_sh <= r_val_sh;
      r_dp_sh  <= r_dp_sh;
      r_en_sh  <= r_en_sh;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Leading-zero blanking: scan from the top nibble down while everything
  // seen so far is zero; a lit decimal point exempts its digit.
  always_comb begin : lzb_calc
    logic v_zero;
    v_zero = 1'b1;
    w_lzb  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero   = v_zero & (r_val_sh[4*i +: 4] == 4'h0);
      w_lzb[i] = v_zero & ~r_dp_sh[i] & (i > 0);
    end
  end
`else
  assign w_lzb = '0;
`endif

  assign w_en_eff = r_en_sh & ~w_lzb;

  // Select the nibble, decimal point and visibility of the current digit.
  always_comb begin
    w_sel    = '0;
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_vis    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_sel[i] = (r_idx == IW'(i));
      w_nib    = w_nib | ({4{w_sel[i]}} & r_val_sh[4*i +: 4]);
      w_dp_sel = w_dp_sel | (w_sel[i] & r_dp_sh[i]);
      w_vis    = w_vis | (w_sel[i] & w_en_eff[i]);
    end
  end

  // Output register: drive the selected digit, or blank everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_tick & w_last_digit;
      if (w_vis) begin
        seg <= glyph(w_nib);
        dp  <= ~w_dp_sel;
        an  <= ~w_sel;
      end else begin
        seg <= 7'b1111111;
        dp  <= 1'b1;
        an  <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Testbench for seven_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4). A behavioural
// model derives the expected outputs from the cycle count since reset
// (digit = cycles / dwell mod digits) and from a copy of the loaded data.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   value = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    digit_en = 4'hF;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state.
  int            m_cyc = 0;
  logic [15:0]   m_val = 16'h0;
  logic [3:0]    m_dp  = 4'h0;
  logic [3:0]    m_en  = 4'hF;

  logic [6:0] glyph_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seven_seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Whether digit d would be lit given the model's shadow contents.
  function automatic logic model_vis(input int d);
    logic v;
    v = m_en[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (m_val >> (4*d)) == 16'h0 && !m_dp[d]) v = 1'b0;
`endif
    return v;
  endfunction

  // One clock: drive inputs, predict, check after the edge, advance model.
  task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    logic [3:0] one;
    int         idx;
    @(negedge clk);
    reset = rst; load = ld; value = v; dp_in = d; digit_en = e;
    one = 4'b0001;
    if (rst) begin
      e_an = 4'hF; e_seg = 7'b1111111; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      idx  = (m_cyc / RD) % ND;
      e_fd = ((m_cyc % (RD*ND)) == (RD*ND - 1));
      if (model_vis(idx)) begin
        e_an  = ~(one << idx);
        e_seg = glyph_tab[m_val[4*idx +: 4]];
        e_dp  = ~m_dp[idx];
      end else begin
        e_an = 4'hF; e_seg = 7'b1111111; e_dp = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("an",         {28'h0, an},         {28'h0, e_an});
    chk("seg",        {25'h0, seg},        {25'h0, e_seg});
    chk("dp",         {31'h0, dp},         {31'h0, e_dp});
    chk("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
    if (rst) begin
      m_cyc = 0; m_val = 16'h0; m_dp = 4'h0; m_en = 4'hF;
    end else begin
      m_cyc++;
      if (ld) begin
        m_val = v; m_dp = d; m_en = e;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    // Reset with a coincident load that must be ignored, then idle scan.
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'h0);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
    idle(40);

    // Mixed-nibble load with one decimal point.
    step(1'b0, 1'b1, 16'hA3F1, 4'b0100, 4'hF);
    idle(20);

    // Load on the last prescaler count of a dwell.
    for (int i = 0; i < RD && (m_cyc % RD) != RD - 1; i++) idle(1);
    step(1'b0, 1'b1, 16'h5B2C, 4'b0001, 4'hF);
    idle(16);

    // Per-digit blanking.
    step(1'b0, 1'b1, 16'h9876, 4'h0, 4'b1010);
    idle(20);

    // Reset in the middle of digit 2.
    for (int i = 0; i < RD*ND && (m_cyc % (RD*ND)) != 2*RD + 2; i++) idle(1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
    idle(12);

    // Leading-zero pattern and an exempting decimal point.
    step(1'b0, 1'b1, 16'h0070, 4'h0, 4'hF);
    idle(20);
    step(1'b0, 1'b1, 16'h0005, 4'b0100, 4'hF);
    idle(20);

    // Randomised traffic, biased toward small values for zero nibbles.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_ld;
      logic [15:0] r_v;
      logic [3:0]  r_e;
      r_rst = ($urandom % 97) == 0;
      r_ld  = ($urandom % 4) == 0;
      r_v   = 16'($urandom);
      if ($urandom % 2 == 0) r_v = r_v >> (4 * ($urandom % 4));
      r_e   = (($urandom % 3) == 0) ? 4'($urandom) : 4'hF;
      step(r_rst, r_ld, r_v, 4'($urandom), r_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
